hermes_i2s_slave_rx: RTL
========================

# hermes_i2s_slave_rx

I2S slave receiver for the codec audio path. It accepts externally generated BCLK, LRCLK and serial data (DIN) from a codec or ADC acting as I2S master, and resynchronises them into the CLK_IN domain. It deserialises the left and right samples and presents each stereo pair with a one-cycle valid strobe. It is the receiving end of the BCLK/LRCLK framing the Hermes clock generator produces: 32 BCLKs per slot, left slot when LRCLK is low, MSB one BCLK after the LRCLK edge.

## Interface
- SAMPLE_W, 16, sample width in bits; range 1..SLOT_BITS-1.
- SLOT_BITS, 32, BCLK periods per LRCLK half-period.
- SYNC_STAGES, 2, synchroniser depth; minimum 2.

Ports:
- CLK_IN  in  1  system clock, 122.88 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- BCLK_in  in  1  external bit clock, asynchronous to CLK_IN.
- LRCLK_in  in  1  external word clock (0 = left slot, 1 = right slot).
- DIN  in  1  serial data, MSB first, changes on BCLK falling edge.
- left_data  out  SAMPLE_W  last complete left sample.
- right_data  out  SAMPLE_W  last complete right sample.
- data_valid  out  1  one-cycle strobe; left_data and right_data update in this cycle.
- locked  out  1  framing is verified.
- frame_err  out  1  one-cycle strobe on a slot-length violation.
- err_count  out  16  saturating error count (see Configuration).

## Operation
- BCLK_in, LRCLK_in and DIN each pass through SYNC_STAGES flops plus one history flop, so all three have equal delay.
- brise is asserted when the synchronised BCLK is 1 and its history is 0.
- All other logic acts only in cycles where brise is asserted. In those cycles it samples the synchronised LRCLK (lr) and DIN.
- A boundary is a brise cycle where lr differs from the lr sampled at the previous brise.
- bit_cnt (clog2(SLOT_BITS) bits) handling:
  - At a boundary, bit_cnt is cleared to 0. The DIN bit at the boundary belongs to the previous slot and is discarded.
  - At a non-boundary brise, bit_cnt increments.
  - While bit_cnt < SAMPLE_W (value before the increment), DIN shifts into shift_reg at the LSB.
- Slot check at each boundary:
  - bit_cnt must equal SLOT_BITS-1; otherwise frame_err is asserted.
  - A non-boundary brise while bit_cnt == SLOT_BITS-1 also asserts frame_err, and bit_cnt saturates.
- States:
  - HUNT: reset state; ignores data. An lr 1→0 boundary moves to LEFT.
  - LEFT: when bit_cnt reaches SAMPLE_W, shift_reg is copied to left_hold. An lr 0→1 boundary moves to RIGHT.
  - RIGHT: when bit_cnt reaches SAMPLE_W, left_hold and shift_reg drive left_data and right_data, and data_valid pulses if locked == 1. An lr 1→0 boundary moves to LEFT and completes one frame.
- Lock:
  - good_cnt (2 bits) increments on each error-free RIGHT→LEFT boundary and saturates at 2.
  - locked = (good_cnt == 2).
- Error handling:
  - Any frame_err clears good_cnt and locked, discards the partial words, and moves to HUNT.
  - If the error occurs on an lr 1→0 boundary, the state moves directly to LEFT instead, with bit_cnt = 0.
- Reset asserted mid-frame clears everything asynchronously. After release, reception restarts from HUNT.
- Reset values are 0 for left_data, right_data, data_valid, locked, frame_err, err_count, shift_reg, bit_cnt and good_cnt. The state resets to HUNT. The lr history and all synchroniser flops reset to 0.

## Timing
- CLK_IN must be at least 4× the BCLK frequency, with BCLK high and low each lasting at least 2 CLK_IN periods. At Hermes rates the ratio is 40.
- Pin-edge to brise: SYNC_STAGES+1 CLK_IN cycles.
- data_valid is asserted, and left_data/right_data take their new values, one CLK_IN cycle after the brise that shifts the SAMPLE_W-th right bit.
- data_valid and frame_err are single-cycle pulses. They are never asserted in consecutive cycles.
- The outputs hold their values between data_valid pulses. There is no backpressure.

## Configuration
- HERMES_I2S_RX_ERR_CNT_EN defined: err_count increments on each frame_err and saturates at 16'hFFFF. It is cleared only by reset.
- Macro undefined: err_count is tied to 0, the counter logic is absent, and the port list is unchanged.

## Structure
- Package hermes_i2s_pkg contains:
  - the state enum (HUNT, LEFT, RIGHT);
  - the default SLOT_BITS of 32;
  - the LR polarity constant LR_LEFT = 1'b0.
- Sub-module hermes_sync_edge (SYNC_STAGES-deep synchroniser, history flop, rise/fall strobes, asynchronous active-low reset) is instantiated three times. The edge outputs of the LRCLK and DIN instances are left unused.

## Test plan
- Three clean frames (BCLK at CLK_IN/40; left 16'hA5C3, right 16'h0F0F repeated):
  - locked rises at the third lr 1→0 boundary (second error-free RIGHT→LEFT boundary after HUNT);
  - first data_valid with left 16'hA5C3 and right 16'h0F0F comes in the frame after that;
  - afterwards, exactly one data_valid per frame.
- Left slot of 31 BCLKs while locked:
  - frame_err pulses once and locked drops;
  - no data_valid until two further clean frames have passed;
  - with HERMES_I2S_RX_ERR_CNT_EN, err_count == 1.
- Right slot of 33 BCLKs while locked:
  - frame_err pulses on the 33rd rise and the state goes to HUNT;
  - reception resumes at the next lr 1→0 boundary.
- reset_n pulsed low for 3 cycles mid-right-slot:
  - all outputs are 0 immediately;
  - no data_valid until relock, i.e. three frames later.
- Walking-one patterns (16'h8000 left, 16'h0001 right):
  - the one-BCLK MSB delay is honoured and the bit order is correct;
  - the padding bits 17..32 do not affect the outputs.

Source files
------------

// File: rtl/hermes_i2s_pkg.sv
// Shared types and constants for the Hermes I2S slave receiver.
// States, default slot length and LRCLK polarity.
package hermes_i2s_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LEFT,
    RIGHT
  } i2s_state_e;

  localparam int   DEF_SLOT_BITS = 32;
  localparam logic LR_LEFT       = 1'b0;

endpackage

// File: rtl/hermes_i2s_rx_sync_edge.sv
// hermes_sync_edge: STAGES-deep synchroniser, history flop, edge strobes.
// Ports: CLK_IN, reset_n, d (async in), q (synced), rise, fall.
module hermes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK_IN,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              hist;

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      hist <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      hist <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/hermes_i2s_slave_rx.sv
// I2S slave receiver: syncs BCLK/LRCLK/DIN into CLK_IN, deserialises
// left/right samples, strobes data_valid once per locked frame.
// Ports: CLK_IN, reset_n, BCLK_in, LRCLK_in, DIN, left_data, right_data,
// data_valid, locked, frame_err, err_count.
// Option: HERMES_I2S_RX_ERR_CNT_EN enables the saturating err_count.
module hermes_i2s_slave_rx
  import hermes_i2s_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK_IN,
  input  logic                reset_n,
  input  logic                BCLK_in,
  input  logic                LRCLK_in,
  input  logic                DIN,
  output logic [SAMPLE_W-1:0] left_data,
  output logic [SAMPLE_W-1:0] right_data,
  output logic                data_valid,
  output logic                locked,
  output logic                frame_err,
  output logic [15:0]         err_count
);

  localparam int CW = $clog2(SLOT_BITS);
  localparam logic [CW-1:0] LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CAP  = CW'(SAMPLE_W - 1);
  localparam logic [CW-1:0] SW   = CW'(SAMPLE_W);

  logic brise, lr_s, din_s;
  logic bclk_q_unused, bclk_fall_unused;
  logic lr_rise_unused, lr_fall_unused;
  logic din_rise_unused, din_fall_unused;

  hermes_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
    .CLK_IN (CLK_IN),
    .reset_n(reset_n),
    .d      (BCLK_in),
    .q      (bclk_q_unused),
    .rise   (brise),
    .fall   (bclk_fall_unused)
  );

  hermes_sync_edge #(.STAGES(SYNC_STAGES)) u_lr (
    .CLK_IN (CLK_IN),
    .reset_n(reset_n),
    .d      (LRCLK_in),
    .q      (lr_s),
    .rise   (lr_rise_unused),
    .fall   (lr_fall_unused)
  );

  hermes_sync_edge #(.STAGES(SYNC_STAGES)) u_din (
    .CLK_IN (CLK_IN),
    .reset_n(reset_n),
    .d      (DIN),
    .q      (din_s),
    .rise   (din_rise_unused),
    .fall   (din_fall_unused)
  );

  i2s_state_e          state, state_nx;
  logic                lr_prev, lr_nx;
  logic [CW-1:0]       bit_cnt, cnt_nx;
  logic [1:0]          good_cnt, good_nx;
  logic [SAMPLE_W-1:0] shift_reg, shift_nx;
  logic [SAMPLE_W-1:0] left_hold, hold_nx;
  logic [SAMPLE_W-1:0] ldat_nx, rdat_nx;
  logic [SAMPLE_W-1:0] shifted;
  logic                dv_nx, err_nx;
  logic                bnd, to_left, to_right;

  assign locked   = (good_cnt == 2'd2);
  assign bnd      = (lr_s != lr_prev);
  assign to_left  = bnd && (lr_s == LR_LEFT);
  assign to_right = bnd && (lr_s != LR_LEFT);
  assign shifted  = SAMPLE_W'({shift_reg, din_s});

  always_comb begin
    state_nx = state;
    lr_nx    = lr_prev;
    cnt_nx   = bit_cnt;
    good_nx  = good_cnt;
    shift_nx = shift_reg;
    hold_nx  = left_hold;
    ldat_nx  = left_data;
    rdat_nx  = right_data;
    dv_nx    = 1'b0;
    err_nx   = 1'b0;
    if (brise) begin
      lr_nx = lr_s;
      if (bnd) begin
        cnt_nx = '0;
        err_nx = (state != HUNT) && (bit_cnt != LAST);
      end else if (bit_cnt == LAST) begin
        err_nx = (state != HUNT);
      end else begin
        cnt_nx = bit_cnt + 1'b1;
      end
      if (!bnd && state != HUNT && bit_cnt < SW)
        shift_nx = shifted;
      if (!bnd && bit_cnt == CAP) begin
        unique case (state)
          LEFT: hold_nx = shifted;
          RIGHT: begin
            if (locked) begin
              ldat_nx = left_hold;
              rdat_nx = shifted;
              dv_nx   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (err_nx) begin
        good_nx  = '0;
        shift_nx = '0;
        hold_nx  = '0;
        state_nx = to_left ? LEFT : HUNT;
      end else if (to_left) begin
        state_nx = LEFT;
        if (state == RIGHT && !locked)
          good_nx = good_cnt + 2'd1;
      end else if (to_right && state == LEFT) begin
        state_nx = RIGHT;
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      lr_prev    <= 1'b0;
      bit_cnt    <= '0;
      good_cnt   <= '0;
      shift_reg  <= '0;
      left_hold  <= '0;
      left_data  <= '0;
      right_data <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      lr_prev    <= lr_nx;
      bit_cnt    <= cnt_nx;
      good_cnt   <= good_nx;
      shift_reg  <= shift_nx;
      left_hold  <= hold_nx;
      left_data  <= ldat_nx;
      right_data <= rdat_nx;
      data_valid <= dv_nx;
      frame_err  <= err_nx;
    end
  end

`ifdef HERMES_I2S_RX_ERR_CNT_EN
  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n)
      err_count <= '0;
    else if (frame_err && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
